// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the RV32 load/store port: one outstanding request,
// programmable wait, word RAM with byte-lane stores and range/alignment checking.
module riscv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             acc_en;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [31:0]      word_off;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             mem_we;

  // With zero wait the access happens on the accept edge, so take the live request.
  always_comb begin
    acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
    acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    acc_be    = (state_q == S_IDLE) ? req_be    : be_q;
    word_off  = (acc_addr - ADDR_BASE) >> 2;
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr < ADDR_BASE) ||
                (word_off >= 32'(DEPTH_WORDS));
    acc_idx   = word_off[IDX_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    acc_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            acc_en  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_en) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
    end
  end

  assign mem_we = acc_en && acc_we && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed self-checking bench for riscv_dmem_responder; a second instance with
// zero wait cycles covers the minimum-latency path.
module tb_riscv_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        f_req_valid = 1'b0, f_req_we = 1'b0, f_rsp_ready = 1'b1;
  logic [31:0] f_req_addr = 32'h0, f_req_wdata = 32'h0;
  logic [3:0]  f_req_be = 4'h0;
  logic        f_req_ready, f_rsp_valid, f_rsp_err, f_busy;
  logic [31:0] f_rsp_rdata;

  int tests = 0;
  int errors = 0;

  riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_1000)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_1000)) u_dut_fast (
    .clk(clk), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_we(f_req_we), .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_be(f_req_be),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_rdata(f_rsp_rdata),
    .rsp_err(f_rsp_err), .busy(f_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; edges counts clock edges from the accept edge (inclusive)
  // until rsp_valid is seen high.
  task automatic applyStimulus(input bit fast, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] rdata, output logic err, output int edges);
    int n;
    logic v;
    @(negedge clk);
    n = 0;
    while (!(fast ? f_req_ready : req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (fast) begin
      f_req_valid = 1'b1; f_req_we = we; f_req_addr = addr; f_req_wdata = wdata; f_req_be = be;
      f_rsp_ready = 1'b1;
    end else begin
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    f_req_valid = 1'b0;
    edges = 1;
    v = fast ? f_rsp_valid : rsp_valid;
    while (!v && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      v = fast ? f_rsp_valid : rsp_valid;
    end
    if (!v) checkOutput("rsp_timeout", 32'(v), 32'h1);
    rdata = fast ? f_rsp_rdata : rsp_rdata;
    err   = fast ? f_rsp_err : rsp_err;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // T1 + T2 (WAIT_CYCLES=2)
    applyStimulus(0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checkOutput("t1_store_err", 32'(er), 32'h0);
    checkOutput("t1_store_rdata", rd, 32'h0);
    checkOutput("t2_store_latency", 32'(lat), 32'd3);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t1_load_data", rd, 32'hDEADBEEF);
    checkOutput("t1_load_err", 32'(er), 32'h0);
    checkOutput("t2_load_latency", 32'(lat), 32'd3);

    // T2 rerun with zero wait cycles
    applyStimulus(1, 1'b1, 32'h1010, 32'h0BADCAFE, 4'hF, rd, er, lat);
    checkOutput("t2_fast_store_latency", 32'(lat), 32'd1);
    applyStimulus(1, 1'b0, 32'h1010, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t2_fast_load_latency", 32'(lat), 32'd1);
    checkOutput("t2_fast_load_data", rd, 32'h0BADCAFE);

    // T3 byte lanes, then be=0000 no-op
    applyStimulus(0, 1'b1, 32'h1004, 32'h11223344, 4'hF, rd, er, lat);
    applyStimulus(0, 1'b1, 32'h1004, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    applyStimulus(0, 1'b0, 32'h1004, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t3_lane_merge", rd, 32'h11BB33DD);
    applyStimulus(0, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checkOutput("t3_be0_err", 32'(er), 32'h0);
    applyStimulus(0, 1'b0, 32'h1004, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t3_be0_unchanged", rd, 32'h11BB33DD);

    // T4 errors and range boundaries
    applyStimulus(0, 1'b1, 32'h1008, 32'hCAFEF00D, 4'hF, rd, er, lat);
    applyStimulus(0, 1'b0, 32'h1002, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t4_misalign_err", 32'(er), 32'h1);
    checkOutput("t4_misalign_rdata", rd, 32'h0);
    applyStimulus(0, 1'b1, 32'h100A, 32'h0, 4'hF, rd, er, lat);
    checkOutput("t4_misalign_store_err", 32'(er), 32'h1);
    applyStimulus(0, 1'b0, 32'h1400, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t4_oor_err", 32'(er), 32'h1);
    checkOutput("t4_oor_rdata", rd, 32'h0);
    applyStimulus(0, 1'b1, 32'h1400, 32'h77777777, 4'hF, rd, er, lat);
    checkOutput("t4_oor_store_err", 32'(er), 32'h1);
    applyStimulus(0, 1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t4_below_err", 32'(er), 32'h1);
    checkOutput("t4_below_rdata", rd, 32'h0);
    applyStimulus(0, 1'b1, 32'h13FC, 32'h5A5A0001, 4'hF, rd, er, lat);
    checkOutput("t4_top_store_err", 32'(er), 32'h0);
    applyStimulus(0, 1'b0, 32'h13FC, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t4_top_load", rd, 32'h5A5A0001);
    checkOutput("t4_top_err", 32'(er), 32'h0);
    applyStimulus(0, 1'b0, 32'h1008, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t4_ram_unchanged_1008", rd, 32'hCAFEF00D);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t4_ram_unchanged_1000", rd, 32'hDEADBEEF);

    // T5 response back-pressure; a store offered meanwhile must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("t5_busy_wait", 32'(busy), 32'h1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t5_valid_rise", 32'(rsp_valid), 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t5_hold_valid", 32'(rsp_valid), 32'h1);
      checkOutput("t5_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      checkOutput("t5_hold_err", 32'(rsp_err), 32'h0);
      checkOutput("t5_hold_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("t5_release_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t5_release_idle", 32'(req_ready), 32'h1);
    checkOutput("t5_release_busy", 32'(busy), 32'h0);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t5_ignored_store", rd, 32'hDEADBEEF);

    // T6 reset during WAIT discards the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("t6_busy_before_reset", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("t6_rst_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t6_rst_ready", 32'(req_ready), 32'h1);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_no_late_rsp", 32'(rsp_valid), 32'h0);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    checkOutput("t6_old_word", rd, 32'hDEADBEEF);

    // Reset during RESP drops the response but keeps the committed store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100C; req_wdata = 32'h55AA55AA; req_be = 4'hF;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("resp_rst_valid_rise", 32'(rsp_valid), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    checkOutput("resp_rst_dropped", 32'(rsp_valid), 32'h0);
    applyStimulus(0, 1'b0, 32'h100C, 32'h0, 4'h0, rd, er, lat);
    checkOutput("resp_rst_committed", rd, 32'h55AA55AA);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
